// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit:
//   - RV32I opcode constants consumed by the decoder FSM and imm_src decode
//   - FSM state encoding (4-bit, fixed; EXEC_U only reachable when the
//     RV_UPPER_IMM_EN macro is defined)
//   - encodings for result_src, alu_src_a, alu_src_b, alu_op and imm_src
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Controller states; encoding 4'hF is unused and recovers to FETCH.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LINK     = 4'd12,
        TRAP     = 4'd13,
        EXEC_U   = 4'd14
    } ctrlStateT;

    // result_src: what drives the Result bus
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_a: ALU operand A
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // alu_src_b: ALU operand B
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // alu_op: hint to the separate ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // imm_src: immediate format selector
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage : riscv_ctrl_pkg

// File: rtl/riscv_imm_src_dec.sv
// -----------------------------------------------------------------------------
// riscv_imm_src_dec
// Purely combinational opcode -> immediate-format decode.
// Ports:
//   op      in  7  instruction opcode
//   imm_src out 3  immediate format (I/S/B/J/U), I for anything unrecognised
// -----------------------------------------------------------------------------
module riscv_imm_src_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule : riscv_imm_src_dec

// File: rtl/riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_multicycle_ctrl
// Multicycle RV32I main controller: an FSM that sequences each instruction
// over 3-5 cycles on a shared memory/ALU datapath. The ALU decoder is external
// and consumes alu_op.
//
// Configuration macro: RV_UPPER_IMM_EN -- when defined, lui/auipc execute via
// EXEC_U; otherwise both opcodes trap as unsupported.
//
// Parameters:
//   MEM_HANDSHAKE  1: memory states wait on mem_ready; 0: mem_ready ignored
//   STATE_W        width of the state_o debug port (encoding is 4 bits)
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   op, funct3_0     opcode and instr[12] (beq/bne select)
//   zero, mem_ready  ALU zero flag, memory completion
//   mem_req, adr_src, mem_write, ir_write, pc_write, reg_write  datapath strobes
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src, jump_sel  mux selects
//   illegal_instr    sticky unsupported-opcode flag
//   state_o          current state (debug)
// -----------------------------------------------------------------------------
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               funct3_0,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [2:0]         imm_src,
    output logic               jump_sel,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_o
);

    ctrlStateT state;
    ctrlStateT stateNext;
    logic      memDone;
    logic      pcUpdate;
    logic      branch;
    logic      illegalReg;

    assign memDone       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state_o       = STATE_W'(state);
    assign illegal_instr = illegalReg;

    riscv_imm_src_dec u_imm_src_dec (
        .op      (op),
        .imm_src (imm_src)
    );

    // State register and sticky illegal flag.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            illegalReg <= 1'b0;
        end else begin
            state <= stateNext;
            if (stateNext == TRAP) begin
                illegalReg <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred; it also sends unused encodings back to FETCH.
        stateNext = FETCH;
        case (state)
            FETCH:    stateNext = memDone ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: stateNext = MEMADR;
                    OP_R:              stateNext = EXEC_R;
                    OP_I:              stateNext = EXEC_I;
                    OP_BRANCH:         stateNext = BRANCH;
                    OP_JAL:            stateNext = JAL;
                    OP_JALR:           stateNext = JALR;
`ifdef RV_UPPER_IMM_EN
                    OP_LUI, OP_AUIPC:  stateNext = EXEC_U;
`endif
                    default:           stateNext = TRAP;
                endcase
            end
            MEMADR:   stateNext = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  stateNext = memDone ? MEMWB : MEMREAD;
            MEMWB:    stateNext = FETCH;
            MEMWRITE: stateNext = memDone ? FETCH : MEMWRITE;
            EXEC_R:   stateNext = ALUWB;
            EXEC_I:   stateNext = ALUWB;
            ALUWB:    stateNext = FETCH;
            BRANCH:   stateNext = FETCH;
            JAL:      stateNext = ALUWB;
            JALR:     stateNext = LINK;
            LINK:     stateNext = FETCH;
            TRAP:     stateNext = TRAP;
`ifdef RV_UPPER_IMM_EN
            EXEC_U:   stateNext = ALUWB;
`endif
            default:  stateNext = FETCH;
        endcase
    end

    // Output logic: Moore decode of state, plus the branch condition on
    // pc_write and mem_ready gating in the memory states.
    always_comb begin
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        jump_sel   = 1'b0;
        pcUpdate   = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = memDone;
                pcUpdate   = memDone;
            end
            DECODE: begin
                // Precompute PC-relative target (branch/jal) into ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = memDone;
            end
            EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            JAL: begin
                // PC <= ALUOut (target from DECODE); ALU computes OldPC+4 link.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pcUpdate  = 1'b1;
            end
            JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                jump_sel   = 1'b1;
                pcUpdate   = 1'b1;
            end
            LINK: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                reg_write  = 1'b1;
            end
`ifdef RV_UPPER_IMM_EN
            EXEC_U: begin
                alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
`endif
            default: ;
        endcase

        pc_write = pcUpdate | (branch & (zero ^ funct3_0));

        // Reset wins over any state decode, including an in-flight handshake.
        if (reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule : riscv_multicycle_ctrl
